// File: rtl/rv_gpio.sv
// rv_gpio: WIDTH-bit GPIO with direction control, atomic set/clear, synchronised inputs and registered reads.
// Define RV_GPIO_IRQ_EN to build IEN/IPOL/ISTAT, the per-bit edge detector and irq; otherwise irq is 0.

module rv_gpio #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] POUT_RST    = '0
) (
   input  logic             clk,
   input  logic             xreset,
   input  logic [4:0]       adr,
   input  logic             cs,
   input  logic [3:0]       we,
   input  logic             re,
   input  logic [31:0]      dw,
   output logic [31:0]      dr,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] pout,
   output logic [WIDTH-1:0] poe,
   output logic             irq
);

   typedef enum logic [2:0] {
      REG_DOUT  = 3'd0,
      REG_DIN   = 3'd1,
      REG_DIR   = 3'd2,
      REG_SET   = 3'd3,
      REG_CLR   = 3'd4,
      REG_IEN   = 3'd5,
      REG_IPOL  = 3'd6,
      REG_ISTAT = 3'd7
   } reg_e;

   reg_e                               sel;
   logic                               wr_en;
   logic                               rd_en;
   logic [31:0]                        wmask;
   logic [WIDTH-1:0]                   wbits;
   logic [WIDTH-1:0]                   wkeep;
   logic                               unused_adr;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                   s;
   logic [WIDTH-1:0]                   dout_q, dout_d;
   logic [WIDTH-1:0]                   dir_q, dir_d;
   logic [31:0]                        rdata;
   logic [31:0]                        dr_q, dr_d;

   assign sel        = reg_e'(adr[4:2]);
   assign wr_en      = cs && (we != 4'd0);
   assign rd_en      = cs && re;
   assign wmask      = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
   // Bits above WIDTH fall away here, so they can never reach a register.
   assign wbits      = WIDTH'(dw & wmask);
   assign wkeep      = ~WIDTH'(wmask);
   assign unused_adr = ^adr[1:0];
   assign s          = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      dout_d = dout_q;
      dir_d  = dir_q;
      if (wr_en) begin
         case (sel)
            REG_DOUT: dout_d = (dout_q & wkeep) | wbits;
            REG_SET:  dout_d = dout_q | wbits;
            REG_CLR:  dout_d = dout_q & ~wbits;
            REG_DIR:  dir_d  = (dir_q & wkeep) | wbits;
            default:  ;
         endcase
      end
   end

`ifdef RV_GPIO_IRQ_EN
   logic [WIDTH-1:0] ien_q, ien_d;
   logic [WIDTH-1:0] ipol_q, ipol_d;
   logic [WIDTH-1:0] istat_q, istat_d;
   logic [WIDTH-1:0] sd_q;
   logic [WIDTH-1:0] ev;
   logic             irq_q;

   assign ev = (ipol_q & ~s & sd_q) | (~ipol_q & s & ~sd_q);

   always_comb begin
      ien_d   = ien_q;
      ipol_d  = ipol_q;
      istat_d = istat_q;
      if (wr_en) begin
         case (sel)
            REG_IEN:   ien_d   = (ien_q & wkeep) | wbits;
            REG_IPOL:  ipol_d  = (ipol_q & wkeep) | wbits;
            REG_ISTAT: istat_d = istat_q & ~wbits;
            default:   ;
         endcase
      end
      // A new event outranks a same-cycle W1C of the same bit.
      istat_d = istat_d | ev;
   end

   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         ien_q   <= '0;
         ipol_q  <= '0;
         istat_q <= '0;
         sd_q    <= '0;
         irq_q   <= 1'b0;
      end else begin
         ien_q   <= ien_d;
         ipol_q  <= ipol_d;
         istat_q <= istat_d;
         sd_q    <= s;
         irq_q   <= |(istat_q & ien_q);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      case (sel)
         REG_DOUT:  rdata = 32'(dout_q);
         REG_DIN:   rdata = 32'(s);
         REG_DIR:   rdata = 32'(dir_q);
`ifdef RV_GPIO_IRQ_EN
         REG_IEN:   rdata = 32'(ien_q);
         REG_IPOL:  rdata = 32'(ipol_q);
         REG_ISTAT: rdata = 32'(istat_q);
`endif
         default:   rdata = '0;
      endcase
   end

   // Captures pre-write state, so a read and write of one register returns the old value.
   assign dr_d = rd_en ? rdata : 32'd0;

   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         sync_q <= '0;
         dout_q <= POUT_RST;
         dir_q  <= '0;
         dr_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample pre-edge values, which the chain relies on.
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         dout_q <= dout_d;
         dir_q  <= dir_d;
         dr_q   <= dr_d;
      end
   end

   assign dr   = dr_q;
   assign pout = dout_q;
   assign poe  = dir_q;

endmodule

// File: tb/tb_rv_gpio.sv
// Self-checking bench for rv_gpio: hand-derived vector table, interrupt corner sequences and
// randomized traffic against a pin-history reference model.

module tb_rv_gpio;

   localparam int         W    = 8;
   localparam int         SYNC = 2;
   localparam logic [7:0] PRST = 8'h5A;
`ifdef RV_GPIO_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        xreset = 1'b0;
   logic [4:0]  adr = '0;
   logic        cs = 1'b0;
   logic [3:0]  we = '0;
   logic        re = 1'b0;
   logic [31:0] dw = '0;
   logic [31:0] dr;
   logic [7:0]  pin = '0;
   logic [7:0]  pout;
   logic [7:0]  poe;
   logic        irq;

   always #5 clk = ~clk;

   rv_gpio #(
      .WIDTH       (W),
      .SYNC_STAGES (SYNC),
      .POUT_RST    (PRST)
   ) dut (
      .clk    (clk),
      .xreset (xreset),
      .adr    (adr),
      .cs     (cs),
      .we     (we),
      .re     (re),
      .dw     (dw),
      .dr     (dr),
      .pin    (pin),
      .pout   (pout),
      .poe    (poe),
      .irq    (irq)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference state: register contents plus a history of sampled pin values (index 0 = newest).
   logic [7:0]  m_dout, m_dir, m_ien, m_ipol, m_istat;
   logic [7:0]  hist[$];
   logic [31:0] e_dr;
   logic        e_irq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %08h expected %08h", name, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_dout  = PRST;
      m_dir   = '0;
      m_ien   = '0;
      m_ipol  = '0;
      m_istat = '0;
      hist.delete();
      for (int i = 0; i <= SYNC; i++) hist.push_back(8'h00);
      e_dr  = '0;
      e_irq = 1'b0;
   endfunction

   // One rising clock edge: pin seen SYNC edges ago is DIN, one edge older is the previous DIN.
   function automatic void model_edge(input logic c, input logic [3:0] w, input logic r,
                                      input logic [4:0] a, input logic [31:0] d, input logic [7:0] p);
      logic [7:0] din_now, din_old, ev, b;
      din_now = hist[SYNC-1];
      din_old = hist[SYNC];
      e_irq = IRQ_BUILD && ((m_istat & m_ien) != 8'h00);
      e_dr  = '0;
      if (c && r) begin
         case (a[4:2])
            3'd0: e_dr = {24'h0, m_dout};
            3'd1: e_dr = {24'h0, din_now};
            3'd2: e_dr = {24'h0, m_dir};
            3'd5: e_dr = IRQ_BUILD ? {24'h0, m_ien}   : 32'h0;
            3'd6: e_dr = IRQ_BUILD ? {24'h0, m_ipol}  : 32'h0;
            3'd7: e_dr = IRQ_BUILD ? {24'h0, m_istat} : 32'h0;
            default: e_dr = '0;
         endcase
      end
      ev = (din_now & ~din_old & ~m_ipol) | (~din_now & din_old & m_ipol);
      // Only byte lane 0 exists in an 8-bit port.
      if (c && w[0]) begin
         b = d[7:0];
         case (a[4:2])
            3'd0: m_dout = b;
            3'd2: m_dir  = b;
            3'd3: m_dout = m_dout | b;
            3'd4: m_dout = m_dout & ~b;
            3'd5: if (IRQ_BUILD) m_ien  = b;
            3'd6: if (IRQ_BUILD) m_ipol = b;
            3'd7: if (IRQ_BUILD) m_istat = m_istat & ~b;
            default: ;
         endcase
      end
      if (IRQ_BUILD) m_istat = m_istat | ev;
      hist.push_front(p);
      void'(hist.pop_back());
   endfunction

   task automatic cycle(input logic c, input logic [4:0] a, input logic [3:0] w, input logic r,
                        input logic [31:0] d, input logic [7:0] p);
      cs  = c;
      adr = a;
      we  = w;
      re  = r;
      dw  = d;
      pin = p;
      @(posedge clk);
      model_edge(c, w, r, a, d, p);
      #1;
      cyc++;
      check("dr", dr, e_dr);
      check("pout", {24'h0, pout}, {24'h0, m_dout});
      check("poe", {24'h0, poe}, {24'h0, m_dir});
      check("irq", {31'h0, irq}, {31'h0, e_irq});
      cs = 1'b0;
      we = '0;
      re = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pout"}, {24'h0, pout}, {24'h0, PRST});
      check({tag, "_poe"},  {24'h0, poe},  32'h0);
      check({tag, "_dr"},   dr,            32'h0);
      check({tag, "_irq"},  {31'h0, irq},  32'h0);
   endtask

   typedef struct {
      logic        c;
      logic [4:0]  a;
      logic [3:0]  w;
      logic        r;
      logic [31:0] d;
      logic [7:0]  p;
      logic [31:0] x_dr;
      logic [7:0]  x_pout;
      logic [7:0]  x_poe;
   } vec_t;

   vec_t tbl[21];

   initial begin
      logic [7:0] rp;

      tbl[0]  = '{1'b1, 5'h00, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_005A, 8'h5A, 8'h00};
      tbl[1]  = '{1'b1, 5'h04, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h5A, 8'h00};
      tbl[2]  = '{1'b1, 5'h08, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h5A, 8'h00};
      tbl[3]  = '{1'b1, 5'h0C, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h5A, 8'h00};
      tbl[4]  = '{1'b1, 5'h10, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h5A, 8'h00};
      tbl[5]  = '{1'b1, 5'h14, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h5A, 8'h00};
      tbl[6]  = '{1'b1, 5'h18, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h5A, 8'h00};
      tbl[7]  = '{1'b1, 5'h1C, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h5A, 8'h00};
      tbl[8]  = '{1'b1, 5'h00, 4'h1, 1'b0, 32'hFFFF_FFA5, 8'h00, 32'h0000_0000, 8'hA5, 8'h00};
      tbl[9]  = '{1'b1, 5'h0C, 4'hF, 1'b0, 32'h0000_000A, 8'h00, 32'h0000_0000, 8'hAF, 8'h00};
      tbl[10] = '{1'b1, 5'h10, 4'hF, 1'b0, 32'h0000_0081, 8'h00, 32'h0000_0000, 8'h2E, 8'h00};
      tbl[11] = '{1'b1, 5'h00, 4'h0, 1'b1, 32'h0000_0000, 8'h00, 32'h0000_002E, 8'h2E, 8'h00};
      tbl[12] = '{1'b1, 5'h08, 4'hF, 1'b0, 32'h0000_000F, 8'h3C, 32'h0000_0000, 8'h2E, 8'h0F};
      tbl[13] = '{1'b1, 5'h04, 4'h0, 1'b1, 32'h0000_0000, 8'h3C, 32'h0000_0000, 8'h2E, 8'h0F};
      tbl[14] = '{1'b1, 5'h04, 4'h0, 1'b1, 32'h0000_0000, 8'h3C, 32'h0000_003C, 8'h2E, 8'h0F};
      tbl[15] = '{1'b1, 5'h08, 4'h0, 1'b1, 32'h0000_0000, 8'h3C, 32'h0000_000F, 8'h2E, 8'h0F};
      tbl[16] = '{1'b1, 5'h00, 4'hF, 1'b1, 32'h0000_0055, 8'h3C, 32'h0000_002E, 8'h55, 8'h0F};
      tbl[17] = '{1'b0, 5'h00, 4'hF, 1'b1, 32'h0000_00FF, 8'h3C, 32'h0000_0000, 8'h55, 8'h0F};
      tbl[18] = '{1'b1, 5'h00, 4'h2, 1'b0, 32'hFFFF_FF00, 8'h3C, 32'h0000_0000, 8'h55, 8'h0F};
      tbl[19] = '{1'b1, 5'h00, 4'hF, 1'b0, 32'hFFFF_FF33, 8'h3C, 32'h0000_0000, 8'h33, 8'h0F};
      tbl[20] = '{1'b1, 5'h00, 4'h0, 1'b1, 32'h0000_0000, 8'h3C, 32'h0000_0033, 8'h33, 8'h0F};

      xreset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      xreset = 1'b1;
      model_reset();

      for (int i = 0; i < 21; i++) begin
         cycle(tbl[i].c, tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].p);
         check($sformatf("vec%0d_dr", i), dr, tbl[i].x_dr);
         check($sformatf("vec%0d_pout", i), {24'h0, pout}, {24'h0, tbl[i].x_pout});
         check($sformatf("vec%0d_poe", i), {24'h0, poe}, {24'h0, tbl[i].x_poe});
      end

`ifdef RV_GPIO_IRQ_EN
      cycle(1'b1, 5'h1C, 4'hF, 1'b0, 32'hFF, 8'h3C);
      cycle(1'b1, 5'h14, 4'hF, 1'b0, 32'h01, 8'h3C);
      cycle(1'b1, 5'h18, 4'hF, 1'b0, 32'h00, 8'h3C);
      // pin[0] rises before edge 1: ISTAT after edge 3, irq after edge 4.
      repeat (3) cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3D);
      check("irq_before", {31'h0, irq}, 32'h0);
      cycle(1'b1, 5'h1C, 4'h0, 1'b1, 32'h0, 8'h3D);
      check("istat_rise", dr, 32'h1);
      check("irq_rise", {31'h0, irq}, 32'h1);
      cycle(1'b1, 5'h1C, 4'hF, 1'b0, 32'h1, 8'h3D);
      check("irq_w1c_edge", {31'h0, irq}, 32'h1);
      cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3D);
      check("irq_fall", {31'h0, irq}, 32'h0);
      repeat (3) cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3C);
      // Two rises on bit 0; the second lands on the same edge as the W1C.
      cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3D);
      cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3C);
      cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3D);
      cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3D);
      check("irq_col_pre", {31'h0, irq}, 32'h1);
      cycle(1'b1, 5'h1C, 4'hF, 1'b0, 32'h1, 8'h3D);
      check("irq_col_w1c", {31'h0, irq}, 32'h1);
      cycle(1'b1, 5'h1C, 4'h0, 1'b1, 32'h0, 8'h3D);
      check("istat_col", dr, 32'h1);
      check("irq_col_after", {31'h0, irq}, 32'h1);
      cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, 8'h3D);
      check("irq_col_hold", {31'h0, irq}, 32'h1);
`else
      cycle(1'b1, 5'h14, 4'hF, 1'b0, 32'hFF, 8'h3C);
      cycle(1'b1, 5'h18, 4'hF, 1'b0, 32'hFF, 8'h3C);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 5'h00, 4'h0, 1'b0, 32'h0, (i % 2 == 0) ? 8'hC3 : 8'h3C);
         check($sformatf("noirq_toggle%0d", i), {31'h0, irq}, 32'h0);
      end
      cycle(1'b1, 5'h1C, 4'h0, 1'b1, 32'h0, 8'h3C);
      check("noirq_istat", dr, 32'h0);
      cycle(1'b1, 5'h14, 4'h0, 1'b1, 32'h0, 8'h3C);
      check("noirq_ien", dr, 32'h0);
      check("noirq_irq", {31'h0, irq}, 32'h0);
`endif

      rp = 8'h3C;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            // Asynchronous reset mid-traffic with pins high: a rising event follows release.
            pin = 8'hFF;
            rp  = 8'hFF;
            xreset = 1'b0;
            #2;
            check_reset_state("midreset");
            @(posedge clk);
            #1;
            check_reset_state("midreset_held");
            xreset = 1'b1;
            model_reset();
         end
         if ($urandom_range(0, 3) == 0) rp = 8'($urandom);
         cycle(($urandom_range(0, 7) != 0),
               5'($urandom),
               ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
               1'($urandom),
               $urandom,
               rp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rv_gpio.md
# rv_gpio

Parametrised GPIO peripheral replacing the fixed 8-bit `pin`/`pout` decode in the SoC top. It sits on the core's data bus beside `rv_sio`, selected by an address-decoded `cs`, and provides a configurable-width output port with direction control and atomic set/clear. It also provides a synchronised input port and per-bit edge interrupts. Read data is registered, which matches the top-level one-cycle read-mux convention.

## Interface
- `WIDTH`, 8: GPIO bit count, 1..32; register bits at or above `WIDTH` read 0 and ignore writes.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..3.
- `POUT_RST`, 0: reset value of `pout`, `WIDTH` bits.
- `clk` in 1: system clock; all state changes on its rising edge.
- `xreset` in 1: asynchronous, active-low reset.
- `adr` in 5: byte offset; `adr[4:2]` selects the register; `adr[1:0]` is ignored.
- `cs` in 1: block select, from the decode of 0xffff0040..0xffff005f.
- `we` in 4: byte write enables; `we[k]` writes bits 8k+7:8k.
- `re` in 1: read enable.
- `dw` in 32: write data.
- `dr` out 32: read data, registered.
- `pin` in WIDTH: asynchronous external inputs.
- `pout` out WIDTH: output data register.
- `poe` out WIDTH: output enables, 1 = drive.
- `irq` out 1: level interrupt, registered.

## Operation
- Register map:
  - 0x00 DOUT: RW.
  - 0x04 DIN: RO, synchronised `pin`.
  - 0x08 DIR: RW, drives `poe`.
  - 0x0C SET: W1S into DOUT, reads 0.
  - 0x10 CLR: W1C on DOUT, reads 0.
  - 0x14 IEN: RW.
  - 0x18 IPOL: RW; per bit, 0 = rising edge, 1 = falling edge.
  - 0x1C ISTAT: W1C.
- Write: occurs when `cs` and `we` is non-zero; only the enabled bytes take effect.
- Read: occurs when `cs && re`. `dr` is loaded with the addressed register. In every other cycle `dr` loads 0.
- Simultaneous `re` and `we` to the same register: the write is performed, and `dr` returns the pre-write value.
- `pout` = DOUT and `poe` = DIR, directly from the flops with no gating.
- Synchroniser: a `SYNC_STAGES`-flop chain per bit produces `s`. One further flop holds `s_d`.
- Edge detection, per bit:
  - `rise = s & ~s_d`, `fall = ~s & s_d`.
  - `ev = IPOL ? fall : rise`.
- `ev` sets the corresponding ISTAT bit regardless of IEN.
- ISTAT set versus W1C in the same cycle: the set wins.
- `irq` is registered as `|(ISTAT & IEN)`.
- Reset values:
  - `pout` = `POUT_RST`.
  - `poe`, `dr`, `irq`, IEN, IPOL, ISTAT = 0.
  - Synchroniser chain and `s_d` = 0.
- Reset asserted mid-operation: every flop returns immediately to its reset value. Because `s_d` resets to 0, a `pin` that is high at reset release produces one rising event after synchronisation.

## Timing
- Read latency is 1 cycle: `re` sampled at edge N, data valid on `dr` after edge N, cleared after edge N+1 unless re-read.
- Writes take effect at the sampling edge. `pout`/`poe` change after edge N.
- Back-to-back accesses are allowed every cycle, with no wait states. `rdy` is not used.
- `pin` transition before edge 1:
  - `s` updates after edge `SYNC_STAGES`.
  - ISTAT sets after edge `SYNC_STAGES`+1.
  - `irq` rises after edge `SYNC_STAGES`+2.
- W1C of the last pending enabled ISTAT bit at edge N: `irq` falls after edge N+1.
- Pulses on `pin` shorter than one `clk` period may be missed. This is not a required behaviour.

## Configuration
- `RV_GPIO_IRQ_EN` defined: IEN, IPOL, ISTAT, the edge detector and `irq` are built as described above.
- `RV_GPIO_IRQ_EN` undefined:
  - Offsets 0x14..0x1C read 0 and ignore writes.
  - `irq` is tied to 0.
  - The `s_d` flop and edge logic are absent.
  - The DOUT, DIN and DIR behaviour and timing are unchanged.

## Test plan
- Reset, then read all 8 offsets → `pout`=`POUT_RST`, `poe`=0, and all reads return 0 except DOUT=`POUT_RST` and DIN=synchronised `pin`.
- WIDTH=8: write DOUT=0xFFFF_FFA5 with `we`=4'b0001, then SET 0x0A, then CLR 0x81 → `pout` sequence 0xA5, 0xAF, 0x2E; DOUT reads 0x0000_002E.
- DIR=0x0F, `pin`=0x3C, with `SYNC_STAGES`=2 → DIN reads 0x3C no earlier than 2 edges after `pin` changes; `poe`=0x0F.
- IEN=0x01, IPOL=0, `pin[0]` 0→1 → ISTAT=0x01 after edge 3 and `irq`=1 after edge 4. Then W1C 0x01 → `irq`=0 one edge later.
- W1C ISTAT bit 0 in the same cycle as a new edge event on bit 0 → ISTAT bit 0 remains 1 and `irq` stays high.
- Build with `RV_GPIO_IRQ_EN` undefined and toggle `pin` → `irq` stays 0 and offset 0x1C reads 0.
